// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package instruction_fetch_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } if_state_e;

endpackage

// File: rtl/instruction_fetch_ifid_reg.sv
// IF/ID pipeline register: flush to a bubble, capture on load, otherwise hold.
module ifid_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INSN = instruction_fetch_pkg::NOP_INSN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [ILEN-1:0] insn_i,
    output logic [XLEN-1:0] pc_o,
    output logic [ILEN-1:0] insn_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] insn_q, insn_d;
    logic            valid_q, valid_d;

    // Flush wins over load so a redirect under stall still kills the slot.
    always_comb begin
        pc_d    = pc_q;
        insn_d  = insn_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc_d    = '0;
            insn_d  = NOP_INSN;
            valid_d = 1'b0;
        end else if (load_i) begin
            pc_d    = pc_i;
            insn_d  = insn_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= '0;
            insn_q  <= NOP_INSN;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign insn_o  = insn_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC, BOOT/RUN/HALT control and IF/ID register.
// Define IF_PERF_CNT_EN to build the delivered-instruction counter.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter int unsigned     MEM_BYTES = 132,
    parameter logic [ILEN-1:0] NOP_INSN  = instruction_fetch_pkg::NOP_INSN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Stall,
    input  logic            Branch_Taken,
    input  logic [XLEN-1:0] Branch_Target,
    input  logic [ILEN-1:0] Instruction,
    output logic [XLEN-1:0] Inst_Address,
    output logic [XLEN-1:0] IFID_PC,
    output logic [ILEN-1:0] IFID_Instruction,
    output logic            IFID_Valid,
    output logic            Misaligned,
    output logic [31:0]     Fetch_Count
);

    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(MEM_BYTES - 3);

    if_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic            misaligned_q;

    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] seq_pc;
    logic            ifid_load;
    logic            ifid_flush;

    assign redirect_pc = {Branch_Target[XLEN-1:2], 2'b00};
    assign seq_pc      = pc_q + 64'd4;

    always_comb begin
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        unique case (state_q)
            RUN: begin
                if (Branch_Taken) ifid_flush = 1'b1;
                else if (!Stall)  ifid_load  = 1'b1;
            end
            default: ifid_flush = 1'b1;
        endcase
    end

    // On a sequential run-off the PC stays on the last in-range word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            unique case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (Branch_Taken) begin
                        pc_q         <= redirect_pc;
                        misaligned_q <= |Branch_Target[1:0];
                        if (redirect_pc >= PC_LIMIT) state_q <= HALT;
                    end else if (!Stall) begin
                        if (seq_pc >= PC_LIMIT) state_q <= HALT;
                        else                    pc_q    <= seq_pc;
                    end
                end
                HALT: begin
                    if (Branch_Taken) begin
                        misaligned_q <= |Branch_Target[1:0];
                        if (redirect_pc < PC_LIMIT) begin
                            pc_q    <= redirect_pc;
                            state_q <= RUN;
                        end
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    ifid_reg #(
        .NOP_INSN(NOP_INSN)
    ) u_ifid_reg (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .pc_i    (pc_q),
        .insn_i  (Instruction),
        .pc_o    (IFID_PC),
        .insn_o  (IFID_Instruction),
        .valid_o (IFID_Valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (ifid_load && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fetch_cnt_q <= '0;
        else        fetch_cnt_q <= fetch_cnt_d;
    end

    assign Fetch_Count = fetch_cnt_q;
`else
    assign Fetch_Count = '0;
`endif

    assign Inst_Address = pc_q;
    assign Misaligned   = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch against a behavioural fetch model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [63:0] LIMIT = 64'd129;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [63:0] Branch_Target = '0;
    logic [31:0] Instruction;
    logic [63:0] Inst_Address;
    logic [63:0] IFID_PC;
    logic [31:0] IFID_Instruction;
    logic        IFID_Valid;
    logic        Misaligned;
    logic [31:0] Fetch_Count;

    logic [31:0] mem [0:32];
    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    instruction_fetch #(
        .RESET_PC (64'h0),
        .MEM_BYTES(132),
        .NOP_INSN (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .Stall           (Stall),
        .Branch_Taken    (Branch_Taken),
        .Branch_Target   (Branch_Target),
        .Instruction     (Instruction),
        .Inst_Address    (Inst_Address),
        .IFID_PC         (IFID_PC),
        .IFID_Instruction(IFID_Instruction),
        .IFID_Valid      (IFID_Valid),
        .Misaligned      (Misaligned),
        .Fetch_Count     (Fetch_Count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(logic [63:0] a);
        if (a < 64'd132) return mem[int'(a >> 2)];
        return 32'hDEAD_BEEF;
    endfunction

    assign Instruction = mem_rd(Inst_Address);

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: 0 = booting, 1 = fetching, 2 = halted.
    int          m_mode = 0;
    logic [63:0] m_pc = '0;
    logic [63:0] m_ipc = '0;
    logic [31:0] m_ins = NOP;
    logic        m_val = 1'b0;
    logic        m_mis = 1'b0;
    longint      m_cnt = 0;

    task automatic m_bubble();
        m_ipc = '0;
        m_ins = NOP;
        m_val = 1'b0;
    endtask

    always @(posedge clk or negedge reset) begin
        logic [63:0] tgt;
        if (!reset) begin
            m_mode = 0; m_pc = '0; m_bubble(); m_mis = 1'b0; m_cnt = 0;
        end else begin
            tgt   = Branch_Target & ~64'd3;
            m_mis = 1'b0;
            if (m_mode == 0) begin
                m_bubble();
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (Branch_Taken) begin
                    m_bubble();
                    m_pc  = tgt;
                    m_mis = (Branch_Target % 4) != 0;
                    if (tgt >= LIMIT) m_mode = 2;
                end else if (!Stall) begin
                    m_ipc = m_pc;
                    m_ins = mem_rd(m_pc);
                    m_val = 1'b1;
                    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                    if (m_pc + 4 >= LIMIT) m_mode = 2;
                    else m_pc = m_pc + 4;
                end
            end else begin
                m_bubble();
                if (Branch_Taken) begin
                    m_mis = (Branch_Target % 4) != 0;
                    if (tgt < LIMIT) begin
                        m_pc = tgt;
                        m_mode = 1;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] exp_count();
`ifdef IF_PERF_CNT_EN
        return m_cnt[31:0];
`else
        return 32'd0;
`endif
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model.Inst_Address", Inst_Address, m_pc);
            check("model.IFID_PC", IFID_PC, m_ipc);
            check("model.IFID_Instruction", {32'd0, IFID_Instruction}, {32'd0, m_ins});
            check("model.IFID_Valid", {63'd0, IFID_Valid}, {63'd0, m_val});
            check("model.Misaligned", {63'd0, Misaligned}, {63'd0, m_mis});
            check("model.Fetch_Count", {32'd0, Fetch_Count}, {32'd0, exp_count()});
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        check("rst.Inst_Address", Inst_Address, 64'h0);
        check("rst.IFID_PC", IFID_PC, 64'h0);
        check("rst.IFID_Instruction", {32'd0, IFID_Instruction}, {32'd0, NOP});
        check("rst.IFID_Valid", {63'd0, IFID_Valid}, 64'd0);
        check("rst.Misaligned", {63'd0, Misaligned}, 64'd0);
        check("rst.Fetch_Count", {32'd0, Fetch_Count}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] w3;
        int r;
        for (int i = 0; i < 33; i++) mem[i] = $urandom;
        w3 = mem[3];

        #3 reset = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        check("init.Inst_Address", Inst_Address, 64'h0);
        check("init.IFID_Valid", {63'd0, IFID_Valid}, 64'd0);
        check("init.IFID_Instruction", {32'd0, IFID_Instruction}, 64'h13);
        @(negedge clk);
        reset = 1'b1;

        tick();
        check("boot.IFID_Valid", {63'd0, IFID_Valid}, 64'd0);
        check("boot.Inst_Address", Inst_Address, 64'h0);
        tick();
        check("first.IFID_Valid", {63'd0, IFID_Valid}, 64'd1);
        check("first.IFID_PC", IFID_PC, 64'h0);
        check("first.Inst_Address", Inst_Address, 64'h4);
        repeat (3) tick();
        check("seq.Inst_Address", Inst_Address, 64'd16);

        Stall = 1'b1;
        repeat (3) tick();
        check("stall.Inst_Address", Inst_Address, 64'd16);
        check("stall.IFID_PC", IFID_PC, 64'd12);
        check("stall.IFID_Instruction", {32'd0, IFID_Instruction}, {32'd0, w3});
        Stall = 1'b0;
        tick();
        check("resume.Inst_Address", Inst_Address, 64'd20);
        check("resume.IFID_PC", IFID_PC, 64'd16);

        Stall = 1'b1; Branch_Taken = 1'b1; Branch_Target = 64'h2C;
        tick();
        check("brstall.Inst_Address", Inst_Address, 64'h2C);
        check("brstall.IFID_Valid", {63'd0, IFID_Valid}, 64'd0);
        check("brstall.IFID_Instruction", {32'd0, IFID_Instruction}, 64'h13);

        Stall = 1'b0; Branch_Target = 64'h7A;
        tick();
        check("mis.Misaligned", {63'd0, Misaligned}, 64'd1);
        check("mis.Inst_Address", Inst_Address, 64'h78);
        Branch_Taken = 1'b0;
        tick();
        check("mis.pulse_end", {63'd0, Misaligned}, 64'd0);
        check("mis.IFID_PC", IFID_PC, 64'h78);

        tick();
        check("end.Inst_Address", Inst_Address, 64'd128);
        tick();
        check("last.IFID_PC", IFID_PC, 64'd128);
        check("last.IFID_Valid", {63'd0, IFID_Valid}, 64'd1);
        tick();
        check("halt.IFID_Valid", {63'd0, IFID_Valid}, 64'd0);
        check("halt.Inst_Address", Inst_Address, 64'd128);
        Stall = 1'b1;
        tick();
        check("halt.stall_ignored", {32'd0, IFID_Instruction}, 64'h13);
        Stall = 1'b0; Branch_Taken = 1'b1; Branch_Target = 64'h0;
        tick();
        check("halt.redirect", Inst_Address, 64'h0);
        Branch_Taken = 1'b0;
        tick();
        check("rerun.IFID_Valid", {63'd0, IFID_Valid}, 64'd1);
        check("rerun.IFID_PC", IFID_PC, 64'h0);

        pulse_reset();
        tick();
        repeat (10) tick();
        Branch_Taken = 1'b1; Branch_Target = 64'h40;
        repeat (2) tick();
        Branch_Taken = 1'b0;
`ifdef IF_PERF_CNT_EN
        check("cnt.ten", {32'd0, Fetch_Count}, 64'd10);
`else
        check("cnt.tied", {32'd0, Fetch_Count}, 64'd0);
`endif
        pulse_reset();

        for (int i = 0; i < 500; i++) begin
            Stall        = ($urandom_range(0, 99) < 30);
            Branch_Taken = ($urandom_range(0, 99) < 12);
            r = $urandom_range(0, 9);
            if (r < 6)       Branch_Target = 64'(4 * $urandom_range(0, 32));
            else if (r < 8)  Branch_Target = 64'($urandom_range(0, 131));
            else if (r == 8) Branch_Target = 64'd132 + 64'($urandom_range(0, 200));
            else             Branch_Target = {$urandom, $urandom};
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
